// File: rtl/pmd_pkg.sv
// Shared types, constants and width helpers for the pattern match detector.
package pmd_pkg;

  localparam int PMD_MAX_W = 32;
  localparam int NO_MATCH  = 0;

  // Slot config stored at the maximum pattern width; unused upper bits stay zero.
  typedef struct packed {
    logic [PMD_MAX_W-1:0] pat;
    logic [PMD_MAX_W-1:0] mask;
    logic                 ena;
  } slot_cfg_t;

  function automatic int id_w(input int num_pat);
    return $clog2(num_pat + 1);
  endfunction

  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int idx_w(input int num_pat);
    return (num_pat > 1) ? $clog2(num_pat) : 1;
  endfunction

endpackage

// File: rtl/pmd_slot.sv
// One pattern slot: config registers, masked comparator and, with
// PMD_HIT_COUNT_EN defined, a saturating hit counter.
module pmd_slot
  import pmd_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_ena,
  input  logic             cmp_en,
  input  logic [PAT_W-1:0] next_shift,
`ifdef PMD_HIT_COUNT_EN
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             hit
);

  slot_cfg_t cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else if (cfg_we) begin
      cfg <= '{pat: PMD_MAX_W'(cfg_pat), mask: PMD_MAX_W'(cfg_mask), ena: cfg_ena};
    end
  end

  // The compare sees the pre-write config when a write lands on the same edge.
  assign hit = cmp_en && cfg.ena &&
               (((PMD_MAX_W'(next_shift) ^ cfg.pat) & cfg.mask) == '0);

`ifdef PMD_HIT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pattern_match_detector.sv
// Serial multi-pattern detector with masked slots and priority-encoded ID.
// Optional per-slot hit counters are built when PMD_HIT_COUNT_EN is defined.
module pattern_match_detector
  import pmd_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_bit,
  input  logic                        ovl_en,
  input  logic                        cfg_we,
  input  logic [idx_w(NUM_PAT)-1:0]   cfg_idx,
  input  logic [PAT_W-1:0]            cfg_pat,
  input  logic [PAT_W-1:0]            cfg_mask,
  input  logic                        cfg_ena,
  output logic                        match,
  output logic [id_w(NUM_PAT)-1:0]    match_id,
  output logic [NUM_PAT-1:0]          match_vec,
  input  logic [idx_w(NUM_PAT)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]            cnt_out
);

  localparam int ID_W   = id_w(NUM_PAT);
  localparam int IDX_W  = idx_w(NUM_PAT);
  localparam int FILL_W = fill_w(PAT_W);

  logic [PAT_W-1:0]   shift_p0;
  logic [FILL_W-1:0]  fill_p0;
  logic [PAT_W-1:0]   next_shift;
  logic               full;
  logic               cmp_en;
  logic [NUM_PAT-1:0] hit;
  logic [ID_W-1:0]    id_nxt;

  logic               match_p1;
  logic [ID_W-1:0]    match_id_p1;
  logic [NUM_PAT-1:0] match_vec_p1;

  assign next_shift = {shift_p0[PAT_W-2:0], in_bit};
  // Widened so fill+1 cannot wrap when PAT_W is one below a power of two.
  assign full       = (32'(fill_p0) + 32'd1) >= 32'(PAT_W);
  assign cmp_en     = in_valid && full;

`ifdef PMD_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_arr [NUM_PAT];
`endif

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
    pmd_slot #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we && (cfg_idx == IDX_W'(k))),
      .cfg_pat    (cfg_pat),
      .cfg_mask   (cfg_mask),
      .cfg_ena    (cfg_ena),
      .cmp_en     (cmp_en),
      .next_shift (next_shift),
`ifdef PMD_HIT_COUNT_EN
      .cnt        (cnt_arr[k]),
`endif
      .hit        (hit[k])
    );
  end

  always_comb begin
    id_nxt = ID_W'(NO_MATCH);
    for (int k = NUM_PAT - 1; k >= 0; k--) begin
      if (hit[k]) id_nxt = ID_W'(k + 1);
    end
  end

  // Stage p0 -> p1: shift/fill update and registered detection outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_p0     <= '0;
      fill_p0      <= '0;
      match_p1     <= 1'b0;
      match_id_p1  <= '0;
      match_vec_p1 <= '0;
    end else begin
      match_p1     <= |hit;
      match_id_p1  <= id_nxt;
      match_vec_p1 <= hit;
      if (in_valid) begin
        shift_p0 <= next_shift;
        if (!ovl_en && (|hit)) begin
          fill_p0 <= '0;
        end else if (fill_p0 != FILL_W'(PAT_W)) begin
          fill_p0 <= fill_p0 + 1'b1;
        end
      end
    end
  end

  assign match     = match_p1;
  assign match_id  = match_id_p1;
  assign match_vec = match_vec_p1;

`ifdef PMD_HIT_COUNT_EN
  always_comb begin
    cnt_out = '0;
    for (int k = 0; k < NUM_PAT; k++) begin
      if (cnt_sel == IDX_W'(k)) cnt_out = cnt_arr[k];
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_pattern_match_detector.sv
// Table-driven directed bench for pattern_match_detector (PAT_W=8, NUM_PAT=4, CNT_W=2).
module tb_pattern_match_detector;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_bit, ovl_en, cfg_we, cfg_ena;
  logic [1:0] cfg_idx, cnt_sel;
  logic [7:0] cfg_pat, cfg_mask;
  logic       match;
  logic [2:0] match_id;
  logic [3:0] match_vec;
  logic [1:0] cnt_out;

  int errors = 0;
  int checks = 0;

  pattern_match_detector #(.PAT_W(8), .NUM_PAT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .ovl_en(ovl_en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
    .cfg_ena(cfg_ena), .match(match), .match_id(match_id), .match_vec(match_vec),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         we;
    logic [1:0] idx;
    logic [7:0] pat;
    logic [7:0] mask;
    bit         ena;
    bit         vld;
    bit         b;
    bit         ovl;
    logic [2:0] eid;
    logic [3:0] evec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit we, logic [1:0] idx, logic [7:0] pat, logic [7:0] mask,
                              bit ena, bit vld, bit b, bit ovl, logic [2:0] eid, logic [3:0] evec);
    vec_t v;
    v = '{rst: r, we: we, idx: idx, pat: pat, mask: mask, ena: ena,
          vld: vld, b: b, ovl: ovl, eid: eid, evec: evec};
    tbl.push_back(v);
  endfunction

  function automatic void rrow();
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endfunction

  function automatic void crow(logic [1:0] idx, logic [7:0] pat, logic [7:0] mask, bit ena);
    add(0, 1, idx, pat, mask, ena, 0, 0, 1, 0, 0);
  endfunction

  function automatic void brow(bit b, bit ovl, logic [2:0] eid, logic [3:0] evec);
    add(0, 0, 0, 0, 0, 0, 1, b, ovl, eid, evec);
  endfunction

  function automatic void grow();
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endfunction

  // Emits the top nbits of v MSB first; only the last bit carries an expected hit.
  function automatic void feed(logic [7:0] v, int nbits, bit ovl, logic [2:0] eid, logic [3:0] evec);
    for (int i = 0; i < nbits; i++) begin
      if (i == nbits - 1) brow(v[7-i], ovl, eid, evec);
      else                brow(v[7-i], ovl, 0, 0);
    end
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; cfg_we = v.we; cfg_idx = v.idx; cfg_pat = v.pat; cfg_mask = v.mask;
    cfg_ena = v.ena; in_valid = v.vld; in_bit = v.b; ovl_en = v.ovl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_bit = 0; ovl_en = 1; cfg_we = 0; cfg_idx = 0;
    cfg_pat = 0; cfg_mask = 0; cfg_ena = 0; cnt_sel = 0;

    rrow(); rrow();
    // Single full-mask pattern; nothing before the 8th bit.
    crow(0, 8'hF0, 8'hFF, 1);
    feed(8'hF0, 8, 1, 1, 4'b0001);
    brow(0, 1, 0, 0);
    // Two slots hit together; lower index wins.
    rrow();
    crow(1, 8'hCC, 8'hFF, 1); crow(2, 8'hCC, 8'hF0, 1);
    feed(8'hCC, 8, 1, 2, 4'b0110);
    // Overlapping: hits at bits 8 and 10.
    rrow(); crow(0, 8'h55, 8'hFF, 1);
    feed(8'h55, 8, 1, 1, 4'b0001);
    brow(0, 1, 0, 0); brow(1, 1, 1, 4'b0001);
    // Non-overlapping: hit at 8, none at 10, next at 16.
    rrow(); crow(0, 8'h55, 8'hFF, 1);
    feed(8'h55, 8, 0, 1, 4'b0001);
    feed(8'h55, 8, 0, 1, 4'b0001);
    // Gaps inside the stream; same-cycle write uses old pattern, then new one.
    rrow(); crow(0, 8'hF0, 8'hFF, 1);
    brow(1, 1, 0, 0); grow(); brow(1, 1, 0, 0); brow(1, 1, 0, 0); grow(); grow();
    brow(1, 1, 0, 0); brow(0, 1, 0, 0); brow(0, 1, 0, 0); grow(); brow(0, 1, 0, 0);
    add(0, 1, 0, 8'hE0, 8'hFF, 1, 1, 0, 1, 1, 4'b0001);
    grow();
    brow(0, 1, 1, 4'b0001);
    grow();
    // Mask=0 slot hits on every accepted bit once full.
    rrow(); crow(3, 8'h00, 8'h00, 1);
    feed(8'hAB, 8, 1, 4, 4'b1000);
    brow(1, 1, 4, 4'b1000);
    // Reset on the would-be 8th bit drops the pending match; 8 fresh bits needed.
    rrow(); crow(0, 8'hF0, 8'hFF, 1);
    feed(8'hF0, 7, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    crow(0, 8'hF0, 8'hFF, 1);
    brow(0, 1, 0, 0);
    feed(8'hF0, 8, 1, 1, 4'b0001);
    // Five hits on slot 0 for the counter check.
    rrow(); crow(0, 8'h00, 8'h00, 1);
    feed(8'h00, 8, 1, 1, 4'b0001);
    for (int i = 0; i < 4; i++) brow(0, 1, 1, 4'b0001);

    for (int r = 0; r < tbl.size(); r++) begin
      apply(tbl[r]);
      chk("match", r, 32'(match), 32'(tbl[r].evec != 0));
      chk("match_id", r, 32'(match_id), 32'(tbl[r].eid));
      chk("match_vec", r, 32'(match_vec), 32'(tbl[r].evec));
    end

    // Counter readout, saturation and clear-on-write.
    @(negedge clk);
    in_valid = 0; cfg_we = 0; rst = 0;
    cnt_sel = 0; #1;
`ifdef PMD_HIT_COUNT_EN
    chk("cnt_sat", -1, 32'(cnt_out), 32'd3);
`else
    chk("cnt_tied", -1, 32'(cnt_out), 32'd0);
`endif
    cnt_sel = 1; #1;
    chk("cnt_other", -1, 32'(cnt_out), 32'd0);
    cnt_sel = 0;
    apply('{rst: 0, we: 1, idx: 0, pat: 8'h00, mask: 8'h00, ena: 1,
            vld: 0, b: 0, ovl: 1, eid: 0, evec: 0});
    chk("cnt_clear", -1, 32'(cnt_out), 32'd0);
    chk("match_idle", -1, 32'(match), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
